// File: rtl/board_ram_writer_if.sv
// board_ram_writer_if
//   Bundles the snapshot handshake, VGA vsync and RAM port A signals of the
//   board RAM writer.
//   slave  : the writer (takes upd_valid/board_in/vs, drives handshake + RAM A)
//   master : the game logic / VGA / RAM side
//   Signals: upd_valid, upd_ready, board_in[63:0], vs,
//            wea, addra[10:0], dina[31:0], done
interface board_ram_writer_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [63:0] board_in;
  logic        vs;
  logic        wea;
  logic [10:0] addra;
  logic [31:0] dina;
  logic        done;

  modport slave (
    input  upd_valid, board_in, vs,
    output upd_ready, wea, addra, dina, done
  );

  modport master (
    output upd_valid, board_in, vs,
    input  upd_ready, wea, addra, dina, done
  );
endinterface

// File: rtl/board_ram_writer.sv
// board_ram_writer
//   Takes a 4x4 board snapshot (16 x 4-bit tile codes) from the game FSM and
//   writes it into port A of the tile-board RAM, one tile per cycle, at
//   BASE_ADDR+i. With SYNC_VS=1 the burst starts on the vs falling edge so
//   the whole board lands inside vertical blanking.
//   Ports:
//     clk  - pixel clock (shared with the VGA controller)
//     rst  - asynchronous, active-low reset
//     bus  - board_ram_writer_if.slave (handshake, vs, RAM port A, done)
//   Parameters: BASE_ADDR, SYNC_VS, MAX_CODE (codes above it are clamped).
//   Optional feature macro: SHADOW_SKIP_EN - keep a shadow of the RAM board
//   and suppress writes of tiles that are already stored.
//   All outputs are registered.
module board_ram_writer #(
  parameter logic [10:0] BASE_ADDR = 11'd256,
  parameter bit          SYNC_VS   = 1'b1,
  parameter logic [3:0]  MAX_CODE  = 4'd11
) (
  input  logic              clk,
  input  logic              rst,
  board_ram_writer_if.slave bus
);

  localparam int NUM_TILES = 16;

  typedef enum logic [1:0] {IDLE, WAIT_VS, WRITE, DONE} state_t;

  state_t      r_state, w_state_nx;
  logic [63:0] r_snap;
  logic [3:0]  r_idx, w_idx_nx;
  logic        r_vs_d;
  logic        r_ready, w_ready_nx;
  logic        r_done, w_done_nx;
  logic        r_wea, w_wea_nx;
  logic [10:0] r_addra;
  logic [31:0] r_dina;

  logic        w_accept;
  logic        w_snap_ld;
  logic        w_emit;
  logic [3:0]  w_emit_idx;
  logic [3:0]  w_emit_code;

  // Clamped views of the stored snapshot and of the live input; the live
  // view feeds tile 0 on the accept edge when writing starts immediately.
  logic [NUM_TILES-1:0][3:0] w_clamp_snap, w_clamp_in;

  for (genvar g = 0; g < NUM_TILES; g++) begin : g_clamp
    assign w_clamp_snap[g] = (r_snap[4*g +: 4] > MAX_CODE) ? MAX_CODE : r_snap[4*g +: 4];
    assign w_clamp_in[g]   = (bus.board_in[4*g +: 4] > MAX_CODE) ? MAX_CODE : bus.board_in[4*g +: 4];
  end

  assign w_accept = bus.upd_valid && r_ready;

`ifdef SHADOW_SKIP_EN
  logic [NUM_TILES-1:0][3:0] r_shadow;
`endif

  // Next state and next registered outputs. w_emit means "present tile
  // w_emit_idx on port A next cycle".
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_snap_ld   = 1'b0;
    w_emit      = 1'b0;
    w_emit_idx  = r_idx;
    w_emit_code = w_clamp_snap[r_idx];
    w_ready_nx  = 1'b0;
    w_done_nx   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_nx = 1'b1;
        if (w_accept) begin
          w_snap_ld  = 1'b1;
          w_ready_nx = 1'b0;
          w_idx_nx   = 4'd0;
          if (SYNC_VS) begin
            w_state_nx = WAIT_VS;
          end else begin
            w_emit      = 1'b1;
            w_emit_idx  = 4'd0;
            w_emit_code = w_clamp_in[0];
            w_idx_nx    = 4'd1;
            w_state_nx  = WRITE;
          end
        end
      end
      WAIT_VS: begin
        // Only a fresh falling edge counts; a board accepted while vs is
        // already low waits for the next frame.
        if (r_vs_d && !bus.vs) begin
          w_emit      = 1'b1;
          w_emit_idx  = 4'd0;
          w_emit_code = w_clamp_snap[0];
          w_idx_nx    = 4'd1;
          w_state_nx  = WRITE;
        end
      end
      WRITE: begin
        w_emit   = 1'b1;
        w_idx_nx = r_idx + 4'd1;
        if (r_idx == 4'd15) w_state_nx = DONE;
      end
      DONE: begin
        w_done_nx  = 1'b1;
        w_ready_nx = 1'b1;
        w_idx_nx   = 4'd0;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

`ifdef SHADOW_SKIP_EN
  assign w_wea_nx = w_emit && (w_emit_code != r_shadow[w_emit_idx]);
`else
  assign w_wea_nx = w_emit;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_idx   <= '0;
      r_vs_d  <= 1'b1;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_wea   <= 1'b0;
      r_addra <= BASE_ADDR;
      r_dina  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_vs_d  <= bus.vs;
      r_ready <= w_ready_nx;
      r_done  <= w_done_nx;
      r_wea   <= w_wea_nx;
      if (w_snap_ld) r_snap <= bus.board_in;
      // Address/data step on every emitted tile, even when the write
      // itself is suppressed by the shadow compare.
      if (w_emit) begin
        r_addra <= BASE_ADDR + {7'd0, w_emit_idx};
        r_dina  <= {28'd0, w_emit_code};
      end
    end
  end

`ifdef SHADOW_SKIP_EN
  // Mirrors what the RAM holds; zero at reset to match the RAM init image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_shadow <= '0;
    else if (w_emit) r_shadow[w_emit_idx] <= w_emit_code;
  end
`endif

  assign bus.upd_ready = r_ready;
  assign bus.wea       = r_wea;
  assign bus.addra     = r_addra;
  assign bus.dina      = r_dina;
  assign bus.done      = r_done;

endmodule
